// File: rtl/adder_tree_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined adder tree.
package adder_tree_pkg;

    localparam int DEFAULT_IN_W = 8;

    // Ceiling log2; a tree over N lanes needs clog2(N) levels.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res++;
            v = v >>> 1;
        end
        return res;
    endfunction

    // Width of one partial sum at tree level k: one carry bit per level.
    function automatic int level_w(input int in_w, input int k);
        return in_w + k;
    endfunction

    // Bit offset of level k inside the flat bus holding every level back to back,
    // with level 0 (the raw input lanes) at offset 0.
    function automatic int lvl_off(input int num_in, input int in_w, input int k);
        int off;
        off = 0;
        for (int m = 0; m < k; m++) begin
            off += (num_in >> m) * level_w(in_w, m);
        end
        return off;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: pairwise sums of the upstream lanes
// with a valid bit and a local ready that lets a bubble be filled under stall.
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int N_LANES = 4,
    parameter int IN_W    = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_up_valid,
    input  logic [N_LANES*IN_W-1:0]                i_up_data,
    input  logic                                   i_dn_ready,
    output logic                                   o_valid,
    output logic [(N_LANES/2)*level_w(IN_W,1)-1:0] o_data,
    output logic                                   o_ready
);

    localparam int OUT_LANES = N_LANES / 2;
    localparam int SUM_W     = level_w(IN_W, 1);

    logic [OUT_LANES*SUM_W-1:0] w_sum;
    logic                       r_valid;
    logic [OUT_LANES*SUM_W-1:0] r_data;

    for (genvar j = 0; j < OUT_LANES; j++) begin : g_pair
        assign w_sum[j*SUM_W +: SUM_W] = SUM_W'(i_up_data[(2*j)*IN_W +: IN_W])
                                       + SUM_W'(i_up_data[(2*j+1)*IN_W +: IN_W]);
    end

    // An empty level can always take new data, even if everything below is stalled.
    assign o_ready = i_dn_ready | ~r_valid;

    // Level register: load pair sums and the upstream valid whenever this level may advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_up_valid;
            r_data  <= w_sum;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/adder_tree_pipe.sv
// Fully pipelined unsigned adder tree, one register level per tree level, with
// valid/ready backpressure and bubble collapsing.
// Optional macro ADDER_TREE_SAT_EN: saturate out_sum to all ones and flag out_ovf
// when the full sum does not fit OUT_W; undefined means wrap-around, out_ovf = 0.
module adder_tree_pipe
    import adder_tree_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int IN_W   = DEFAULT_IN_W,
    parameter int OUT_W  = IN_W + clog2(NUM_IN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_IN*IN_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_sum,
    output logic                   out_ovf
);

    localparam int LEVELS = clog2(NUM_IN);
    localparam int FULL_W = level_w(IN_W, LEVELS);
    localparam int BUS_W  = lvl_off(NUM_IN, IN_W, LEVELS + 1);
    localparam int FIN_OFF = lvl_off(NUM_IN, IN_W, LEVELS);

    logic [BUS_W-1:0]  w_bus;
    logic [LEVELS:0]   w_valid;
    logic [LEVELS:1]   w_dn_ready;
    logic [LEVELS:1]   w_ready;
    logic [FULL_W-1:0] w_full;

    assign w_bus[NUM_IN*IN_W-1:0] = in_data;
    assign w_valid[0]             = in_valid;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int LANES   = NUM_IN >> (k - 1);
        localparam int LW      = level_w(IN_W, k - 1);
        localparam int OFF_UP  = lvl_off(NUM_IN, IN_W, k - 1);
        localparam int OFF_OUT = lvl_off(NUM_IN, IN_W, k);

        // Ready into level k is the unrolled chain: the consumer pops, or some
        // deeper level is empty. Built from valid bits only, so there is no
        // combinational path from one ready to the next.
        if (k == LEVELS) begin : g_last
            assign w_dn_ready[k] = out_ready;
        end else begin : g_mid
            assign w_dn_ready[k] = out_ready | ~(&w_valid[LEVELS:k+1]);
        end

        adder_tree_level #(
            .N_LANES (LANES),
            .IN_W    (LW)
        ) u_level (
            .clk        (clk),
            .rst        (rst),
            .i_up_valid (w_valid[k-1]),
            .i_up_data  (w_bus[OFF_UP +: LANES*LW]),
            .i_dn_ready (w_dn_ready[k]),
            .o_valid    (w_valid[k]),
            .o_data     (w_bus[OFF_OUT +: (LANES/2)*(LW+1)]),
            .o_ready    (w_ready[k])
        );
    end

    // Level 1 is ready exactly when any level is ready (a deeper ready level
    // implies level 1 can shift too), so the OR equals the level-1 ready.
    assign in_ready  = (|w_ready) & ~rst;
    assign out_valid = w_valid[LEVELS];
    assign w_full    = w_bus[FIN_OFF +: FULL_W];

`ifdef ADDER_TREE_SAT_EN
    localparam logic [FULL_W-1:0] SAT_MAX = {FULL_W{1'b1}} >> (FULL_W - OUT_W);

    logic w_ovf;

    // Saturating output: clamp to all ones when the full sum exceeds OUT_W bits.
    always_comb begin
        w_ovf   = (w_full > SAT_MAX);
        out_ovf = w_ovf;
        out_sum = w_ovf ? '1 : OUT_W'(w_full);
    end
`else
    assign out_sum = OUT_W'(w_full);
    assign out_ovf = 1'b0;
`endif

endmodule

// File: doc/adder_tree_pipe.md
# adder_tree_pipe

Parametrised, fully pipelined unsigned adder tree. It reduces NUM_IN lanes of IN_W bits to one sum, with one register level per tree level and a valid/ready handshake that supports backpressure and bubble collapsing. It is the next generation of the fixed two-level 8-bit reduction stage and replaces hand-instantiated adder/register pairs in the datapath.

## Interface
- NUM_IN, 4: number of input lanes; power of two, at least 2. LEVELS = log2(NUM_IN).
- IN_W, 8: width of each input lane.
- OUT_W, IN_W+LEVELS: output sum width; at least 1 and at most IN_W+LEVELS.
- clk  input  1: single clock; all state updates on the rising edge.
- rst  input  1: synchronous, active-high reset.
- in_valid  input  1: in_data holds a vector.
- in_ready  output  1: the block accepts a vector this cycle.
- in_data  input  NUM_IN*IN_W: lane i is in_data[i*IN_W +: IN_W].
- out_valid  output  1: out_sum is valid.
- out_ready  input  1: the consumer takes out_sum this cycle.
- out_sum  output  OUT_W: reduced sum.
- out_ovf  output  1: the sum did not fit in OUT_W (see Configuration).

## Operation
- Arithmetic is unsigned throughout.
- Level k (1..LEVELS) holds NUM_IN>>k partial sums, each IN_W+k bits wide. No bits are lost inside the tree; the full-width sum is IN_W+LEVELS bits.
- Level k sum j = level k-1 sum 2j + level k-1 sum 2j+1. Level 0 is in_data.
- Each level k has one register bank and a valid bit v[k].
- Ready chain, combinational:
  - r[LEVELS] = out_ready | ~v[LEVELS]
  - r[k] = r[k+1] | ~v[k]
  - in_ready = r[1] & ~rst
- Level k loads when r[k] is 1:
  - v[k] takes v[k-1]; v[0] is in_valid.
  - Data takes the sums from level k-1.
- Level k holds its value when r[k] is 0.
- A bubble (v=0) in any level is filled even while downstream stalls (bubble collapsing).
- out_valid = v[LEVELS].
- out_sum and out_ovf come from the final register through the output-width logic (Configuration). They are combinational from the final register only.
- A transfer occurs on in_valid & in_ready, or on out_valid & out_ready.
- Sums leave in strict acceptance order; none is dropped or duplicated.
- in_data is ignored when in_valid is 0. Data registers may load X-free don't-care values, but valid bits gate every output.

## Timing
- Reset, while rst=1 at an edge:
  - all v[k] cleared and all data registers cleared
  - out_valid=0, out_sum=0, out_ovf=0
  - in_ready=0 while rst is high
- Reset mid-operation discards every in-flight sum. The first cycle after reset has in_ready=1.
- Latency with no stall: a vector accepted at edge t appears with out_valid=1 after edge t+LEVELS-1. That is LEVELS cycles from the accept cycle to the output cycle.
- Throughput: one vector per cycle while out_ready=1.
- Capacity: LEVELS vectors in flight. With out_ready held low, exactly LEVELS vectors are accepted, then in_ready drops.
- Simultaneous output pop and input push at full occupancy is allowed: in_ready=1 in the same cycle as out_ready=1.
- out_sum and out_valid stay stable while out_valid=1 and out_ready=0.

## Configuration
- ADDER_TREE_SAT_EN is defined (saturation):
  - If the full sum > 2^OUT_W-1, out_sum = all ones and out_ovf = 1.
  - Otherwise out_sum = the full sum and out_ovf = 0.
- ADDER_TREE_SAT_EN is undefined (wrap):
  - out_sum = the full sum mod 2^OUT_W.
  - out_ovf is tied 0.
  - No compare logic is built.
- When OUT_W = IN_W+LEVELS, both builds are bit-identical and out_ovf is constant 0.

## Structure
- Package adder_tree_pkg:
  - a clog2 function
  - a localparam helper for level width (IN_W+k)
  - a default width constant
- Sub-module adder_tree_level: one registered level.
  - Parameters: lane count and input width.
  - Ports: clk, rst, upstream valid/data, downstream ready, valid/data out, and local ready.
- The top generates LEVELS instances and the output-width logic.

## Test plan
- Basic sum (NUM_IN=4, IN_W=8, OUT_W=10): push {1,2,3,4} with out_ready=1 → out_sum=10, out_valid=1 exactly 2 cycles after accept, out_ovf=0.
- Full range: push {255,255,255,255} → out_sum=1020, then push {0,0,0,0} on the next cycle → out_sum=0 on the following output cycle.
- Backpressure: out_ready=0, present vectors A={1,1,1,1}, B={2,2,2,2}, C={3,3,3,3} back to back → A and B accepted and in_ready=0 for C. Raise out_ready → outputs 4, 8, 12 in order, with no loss or duplication.
- Bubble collapse: with out_ready=0 and one vector in the last level, push a new vector → accepted; in_ready drops only after LEVELS vectors are in flight.
- Output width (OUT_W=8): input {100,100,100,100} → out_sum=255 and out_ovf=1 with ADDER_TREE_SAT_EN; out_sum=144 and out_ovf=0 without it.
- Reset mid-flight: accept two vectors, assert rst for 1 cycle → out_valid=0, out_sum=0, in_ready=0 during reset, no stale sums afterward, and in_ready=1 on the first post-reset cycle.
